// File: rtl/elevator_req_scheduler.sv
// LOOK-policy floor request scheduler: captures button edges into pending, issues one target at a time over valid/ready.
// Optional door dwell between arrival and reselect is enabled by defining ELEVATOR_SCHED_DWELL_EN.
module elevator_req_scheduler #(
  parameter int NUM_FLOORS   = 5,
  parameter int FLOOR_W      = 3,
  parameter int DWELL_CYCLES = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NUM_FLOORS-1:0] btn,
  input  logic [FLOOR_W-1:0]    cur_floor,
  input  logic                  arrived,
  output logic                  tgt_valid,
  input  logic                  tgt_ready,
  output logic [FLOOR_W-1:0]    tgt_floor,
  output logic [NUM_FLOORS-1:0] pending,
  output logic                  dir_up,
  output logic                  busy
);

`ifdef ELEVATOR_SCHED_DWELL_EN
  typedef enum logic [2:0] {IDLE, SELECT, ISSUE, WAIT_ARRIVE, DWELL} state_t;
`else
  typedef enum logic [1:0] {IDLE, SELECT, ISSUE, WAIT_ARRIVE} state_t;
`endif

  state_t state, state_nxt;

  logic [NUM_FLOORS-1:0] btn_q;
  logic [NUM_FLOORS-1:0] set_vec;
  logic [NUM_FLOORS-1:0] clr_vec;
  logic                  arrive_hit;
  logic                  any_pending;

  logic                  ge_hit, gt_hit, le_hit, lt_hit;
  logic [FLOOR_W-1:0]    ge_f, gt_f, le_f, lt_f;
  logic [FLOOR_W-1:0]    sel_floor;
  logic                  sel_dir;

`ifdef ELEVATOR_SCHED_DWELL_EN
  logic [7:0]            dwell_cnt;
`endif

  assign any_pending = |pending;
  assign set_vec     = btn & ~btn_q;
  assign arrive_hit  = (state == WAIT_ARRIVE) && arrived && (cur_floor == tgt_floor);
  assign tgt_valid   = (state == ISSUE);
  assign busy        = (state != IDLE);

  always_comb begin
    clr_vec = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      clr_vec[f] = arrive_hit && (tgt_floor == FLOOR_W'(f));
    end
  end

  // Candidate searches: descending loops keep the lowest match, ascending keep the highest.
  always_comb begin
    ge_hit = 1'b0; ge_f = '0;
    gt_hit = 1'b0; gt_f = '0;
    le_hit = 1'b0; le_f = '0;
    lt_hit = 1'b0; lt_f = '0;
    for (int f = NUM_FLOORS - 1; f >= 0; f--) begin
      if (pending[f] && (FLOOR_W'(f) >= cur_floor)) begin
        ge_hit = 1'b1;
        ge_f   = FLOOR_W'(f);
      end
      if (pending[f] && (FLOOR_W'(f) > cur_floor)) begin
        gt_hit = 1'b1;
        gt_f   = FLOOR_W'(f);
      end
    end
    for (int f = 0; f < NUM_FLOORS; f++) begin
      if (pending[f] && (FLOOR_W'(f) <= cur_floor)) begin
        le_hit = 1'b1;
        le_f   = FLOOR_W'(f);
      end
      if (pending[f] && (FLOOR_W'(f) < cur_floor)) begin
        lt_hit = 1'b1;
        lt_f   = FLOOR_W'(f);
      end
    end
  end

  always_comb begin
    sel_floor = tgt_floor;
    sel_dir   = dir_up;
    if (dir_up) begin
      if (ge_hit) begin
        sel_floor = ge_f;
        sel_dir   = 1'b1;
      end else if (lt_hit) begin
        sel_floor = lt_f;
        sel_dir   = 1'b0;
      end
    end else begin
      if (le_hit) begin
        sel_floor = le_f;
        sel_dir   = 1'b0;
      end else if (gt_hit) begin
        sel_floor = gt_f;
        sel_dir   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:        if (any_pending) state_nxt = SELECT;
      SELECT:      state_nxt = any_pending ? ISSUE : IDLE;
      ISSUE:       if (tgt_ready) state_nxt = WAIT_ARRIVE;
`ifdef ELEVATOR_SCHED_DWELL_EN
      WAIT_ARRIVE: if (arrive_hit) state_nxt = DWELL;
      DWELL:       if (dwell_cnt == 8'(DWELL_CYCLES - 1)) state_nxt = SELECT;
`else
      WAIT_ARRIVE: if (arrive_hit) state_nxt = SELECT;
`endif
      default:     state_nxt = IDLE;
    endcase
  end

  // Clear beats a same-cycle set: the passenger at that floor is already served.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      btn_q   <= '0;
      pending <= '0;
    end else begin
      btn_q   <= btn;
      pending <= (pending | set_vec) & ~clr_vec;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tgt_floor <= '0;
      dir_up    <= 1'b1;
    end else if ((state == SELECT) && any_pending) begin
      tgt_floor <= sel_floor;
      dir_up    <= sel_dir;
    end
  end

`ifdef ELEVATOR_SCHED_DWELL_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
    end else if (state == DWELL) begin
      dwell_cnt <= dwell_cnt + 8'd1;
    end else begin
      dwell_cnt <= '0;
    end
  end
`endif

endmodule

// File: tb/tb_elevator_req_scheduler.sv
// Directed bench for elevator_req_scheduler: reset, LOOK order, backpressure, mismatch, async reset, held button.
module tb_elevator_req_scheduler;
  localparam int NF = 5;
  localparam int FW = 3;
  localparam int DC = 8;
`ifdef ELEVATOR_SCHED_DWELL_EN
  localparam int DW = DC;
`else
  localparam int DW = 0;
`endif

  logic          clk;
  logic          reset;
  logic [NF-1:0] btn;
  logic [FW-1:0] cur_floor;
  logic          arrived;
  logic          tgt_valid;
  logic          tgt_ready;
  logic [FW-1:0] tgt_floor;
  logic [NF-1:0] pending;
  logic          dir_up;
  logic          busy;

  int n_checks = 0;
  int n_fails  = 0;

  elevator_req_scheduler #(.NUM_FLOORS(NF), .FLOOR_W(FW), .DWELL_CYCLES(DC)) dut (
    .clk(clk), .reset(reset), .btn(btn), .cur_floor(cur_floor), .arrived(arrived),
    .tgt_valid(tgt_valid), .tgt_ready(tgt_ready), .tgt_floor(tgt_floor),
    .pending(pending), .dir_up(dir_up), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (tgt_valid) break;
      step();
    end
    check(tag, 32'(tgt_valid), 32'd1);
  endtask

  // Wait for a target, check it, accept it, then report arrival there.
  task automatic serve(input string tag, input logic [FW-1:0] fl, input logic dir);
    wait_valid({tag, "_valid"});
    check({tag, "_floor"}, 32'(tgt_floor), 32'(fl));
    check({tag, "_dir"}, 32'(dir_up), 32'(dir));
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;
    cur_floor = fl;
    arrived   = 1'b1;
    step();
    arrived   = 1'b0;
  endtask

  initial begin
    reset = 1'b0; btn = '0; cur_floor = '0; arrived = 1'b0; tgt_ready = 1'b0;
    #1 reset = 1'b1;
    step();
    check("rst_valid", 32'(tgt_valid), 32'd0);
    check("rst_floor", 32'(tgt_floor), 32'd0);
    check("rst_pending", 32'(pending), 32'd0);
    check("rst_dir", 32'(dir_up), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step();

    // Single press, latency and retirement
    btn = 5'b01000;
    step();
    check("t1_pending", 32'(pending), 32'b01000);
    check("t1_idle", 32'(busy), 32'd0);
    btn = '0;
    step();
    check("t1_select_busy", 32'(busy), 32'd1);
    check("t1_select_valid", 32'(tgt_valid), 32'd0);
    step();
    check("t1_issue_valid", 32'(tgt_valid), 32'd1);
    check("t1_issue_floor", 32'(tgt_floor), 32'd3);
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;
    check("t1_wait_valid", 32'(tgt_valid), 32'd0);
    cur_floor = 3'd3;
    arrived   = 1'b1;
    step();
    arrived = 1'b0;
    check("t1_cleared", 32'(pending), 32'd0);
    for (int i = 0; i < DW; i++) step();
    check("t1_select_after_dwell", 32'(busy), 32'd1);
    step();
    check("t1_back_idle", 32'(busy), 32'd0);

    // LOOK ordering from floor 2 going up
    cur_floor = 3'd2;
    btn = 5'b11001;
    step();
    btn = '0;
    check("t2_pending", 32'(pending), 32'b11001);
    serve("t2_first", 3'd3, 1'b1);
    serve("t2_second", 3'd4, 1'b1);
    serve("t2_third", 3'd0, 1'b0);
    check("t2_empty", 32'(pending), 32'd0);

    // Backpressure: target held while a new press lands
    btn = 5'b10000;
    step();
    btn = '0;
    wait_valid("t3_valid");
    check("t3_floor", 32'(tgt_floor), 32'd4);
    check("t3_dir", 32'(dir_up), 32'd1);
    for (int i = 0; i < 10; i++) begin
      btn = (i == 2) ? 5'b00010 : 5'b00000;
      step();
      check("t3_hold_valid", 32'(tgt_valid), 32'd1);
      check("t3_hold_floor", 32'(tgt_floor), 32'd4);
    end
    btn = '0;
    check("t3_pending", 32'(pending), 32'b10010);
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;

    // Arrival at the wrong floor is ignored
    cur_floor = 3'd3;
    arrived   = 1'b1;
    step();
    arrived = 1'b0;
    check("t5_no_clear", 32'(pending), 32'b10010);
    check("t5_busy", 32'(busy), 32'd1);
    step();
    step();
    check("t5_still_waiting", 32'(tgt_valid), 32'd0);
    btn = 5'b00100;
    step();
    btn = '0;
    check("t6_pending_pre", 32'(pending), 32'b10110);

    // Asynchronous reset mid-operation
    #2 reset = 1'b1;
    #1;
    check("t6_valid", 32'(tgt_valid), 32'd0);
    check("t6_floor", 32'(tgt_floor), 32'd0);
    check("t6_pending", 32'(pending), 32'd0);
    check("t6_dir", 32'(dir_up), 32'd1);
    check("t6_busy", 32'(busy), 32'd0);
    step();
    reset = 1'b0;
    cur_floor = 3'd0;
    step();

    // Held button with a same-cycle set and clear
    btn = 5'b00100;
    step();
    check("t4_pending", 32'(pending), 32'b00100);
    wait_valid("t4_valid");
    check("t4_floor", 32'(tgt_floor), 32'd2);
    tgt_ready = 1'b1;
    step();
    tgt_ready = 1'b0;
    btn = '0;
    step();
    btn       = 5'b00100;
    cur_floor = 3'd2;
    arrived   = 1'b1;
    step();
    arrived = 1'b0;
    check("t4_clear_wins", 32'(pending), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check("t4_held_no_reset", 32'(pending), 32'd0);
    end
    btn = '0;
    step();
    btn = 5'b00100;
    step();
    check("t4_repress", 32'(pending), 32'b00100);
    btn = '0;
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end
endmodule
